// File: rtl/nts_parser_pkg.sv
// Shared encodings for the NTS parser blocks: walker states, error codes and
// RAM access-port word sizes.
package nts_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EVAL  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } walk_state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_HDR_BOUNDS = 3'd1;
    localparam logic [2:0] ERR_MISALIGNED = 3'd2;
    localparam logic [2:0] ERR_TOO_SHORT  = 3'd3;
    localparam logic [2:0] ERR_OVERRUN    = 3'd4;
    localparam logic [2:0] ERR_TABLE_FULL = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd6;

    localparam logic [2:0] WS_8  = 3'd0;
    localparam logic [2:0] WS_16 = 3'd1;
    localparam logic [2:0] WS_32 = 3'd2;
    localparam logic [2:0] WS_64 = 3'd3;

endpackage

// File: rtl/nts_extension_walker_if.sv
// Receive-RAM access port: the walker is the master issuing reads, the RAM
// arbiter is the slave returning data.
interface nts_extension_walker_if #(
    parameter int BW = 13
);
    logic [BW-1:0] access_port_addr;
    logic [2:0]    access_port_wordsize;
    logic          access_port_rd_en;
    logic          access_port_wait;
    logic          access_port_rd_dv;
    logic [63:0]   access_port_rd_data;

    modport master (
        output access_port_addr, access_port_wordsize, access_port_rd_en,
        input  access_port_wait, access_port_rd_dv, access_port_rd_data
    );

    modport slave (
        input  access_port_addr, access_port_wordsize, access_port_rd_en,
        output access_port_wait, access_port_rd_dv, access_port_rd_data
    );
endinterface

// File: rtl/nts_ext_table.sv
// Extension table: one write port, one registered read port; entries at or
// beyond the current count read back as zero.
module nts_ext_table #(
    parameter int MAX_EXTENSIONS = 8,
    parameter int BW             = 13,
    parameter int CW             = 4
) (
    input  logic          i_clk,
    input  logic          i_areset,
    input  logic          i_clear,
    input  logic          i_wr_en,
    input  logic [CW-1:0] i_wr_index,
    input  logic [15:0]   i_wr_tag,
    input  logic [15:0]   i_wr_length,
    input  logic [BW-1:0] i_wr_addr,
    input  logic [CW-1:0] i_rd_index,
    input  logic [CW-1:0] i_count,
    output logic [15:0]   o_rd_tag,
    output logic [15:0]   o_rd_length,
    output logic [BW-1:0] o_rd_addr
);
    logic [15:0]   tag_reg    [MAX_EXTENSIONS];
    logic [15:0]   length_reg [MAX_EXTENSIONS];
    logic [BW-1:0] addr_reg   [MAX_EXTENSIONS];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_EXTENSIONS; gi++) begin : g_entry
            always_ff @(posedge i_clk or posedge i_areset) begin
                if (i_areset) begin
                    tag_reg[gi]    <= '0;
                    length_reg[gi] <= '0;
                    addr_reg[gi]   <= '0;
                end else if (i_clear) begin
                    tag_reg[gi]    <= '0;
                    length_reg[gi] <= '0;
                    addr_reg[gi]   <= '0;
                end else if (i_wr_en && i_wr_index == CW'(gi)) begin
                    tag_reg[gi]    <= i_wr_tag;
                    length_reg[gi] <= i_wr_length;
                    addr_reg[gi]   <= i_wr_addr;
                end
            end
        end
    endgenerate

    // Explicit select mux keeps the read index width independent of table depth.
    logic [15:0]   sel_tag_next;
    logic [15:0]   sel_length_next;
    logic [BW-1:0] sel_addr_next;

    always_comb begin
        sel_tag_next    = '0;
        sel_length_next = '0;
        sel_addr_next   = '0;
        for (int i = 0; i < MAX_EXTENSIONS; i++) begin
            if (i_rd_index == CW'(i) && i_rd_index < i_count) begin
                sel_tag_next    = tag_reg[i];
                sel_length_next = length_reg[i];
                sel_addr_next   = addr_reg[i];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_rd_tag    <= '0;
            o_rd_length <= '0;
            o_rd_addr   <= '0;
        end else if (i_clear) begin
            o_rd_tag    <= '0;
            o_rd_length <= '0;
            o_rd_addr   <= '0;
        end else begin
            o_rd_tag    <= sel_tag_next;
            o_rd_length <= sel_length_next;
            o_rd_addr   <= sel_addr_next;
        end
    end
endmodule

// File: rtl/nts_extension_walker.sv
// Walks the NTP extension-field chain in receive RAM, validating each header
// and recording tag/length/address per extension.
module nts_extension_walker
    import nts_parser_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int MAX_EXTENSIONS = 8,
    parameter int MIN_EXT_LENGTH = 16,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int BW            = ADDR_WIDTH + 3,
    localparam int CW            = $clog2(MAX_EXTENSIONS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_clear,
    input  logic                  i_start,
    input  logic [BW-1:0]         i_ext_addr,
    input  logic [BW-1:0]         i_memory_bound,
    nts_extension_walker_if.master access_port,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [2:0]            o_error_code,
    output logic [CW-1:0]         o_ext_count,
    input  logic [CW-1:0]         i_ext_index,
    output logic [15:0]           o_ext_tag,
    output logic [15:0]           o_ext_length,
    output logic [BW-1:0]         o_ext_addr
);
    // Wide enough that neither a BW-bit address plus a 16-bit length nor
    // the header-end compare can wrap.
    localparam int NW = ((BW > 16) ? BW : 16) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    walk_state_t   state_reg;
    logic [BW-1:0] addr_reg;
    logic [BW-1:0] bound_reg;
    logic [15:0]   tag_reg;
    logic [15:0]   length_reg;
    logic [CW-1:0] count_reg;
    logic [TW-1:0] timer_reg;
    logic          done_reg;
    logic          error_reg;
    logic [2:0]    code_reg;
    logic          rd_en_reg;
    logic [BW-1:0] rd_addr_reg;
    logic [2:0]    wordsize_reg;

    logic [NW-1:0] next_addr;
    logic [NW-1:0] hdr_end;
    logic [NW-1:0] bound_ext;
    logic [2:0]    eval_code;
    logic          table_wr_en;
    logic          unused_rd_data;

    assign next_addr = NW'(addr_reg) + NW'(length_reg);
    assign hdr_end   = NW'(addr_reg) + NW'(4);
    assign bound_ext = NW'(bound_reg);
    assign unused_rd_data = ^access_port.access_port_rd_data[63:32];

    always_comb begin
        eval_code = ERR_NONE;
        if (length_reg[1:0] != 2'b00)
            eval_code = ERR_MISALIGNED;
        else if (length_reg < 16'(MIN_EXT_LENGTH))
            eval_code = ERR_TOO_SHORT;
        else if (next_addr > bound_ext)
            eval_code = ERR_OVERRUN;
        else if (count_reg == CW'(MAX_EXTENSIONS))
            eval_code = ERR_TABLE_FULL;
    end

    assign table_wr_en = (state_reg == ST_EVAL) && (eval_code == ERR_NONE);

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset || i_clear) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            bound_reg    <= '0;
            tag_reg      <= '0;
            length_reg   <= '0;
            count_reg    <= '0;
            timer_reg    <= '0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            code_reg     <= ERR_NONE;
            rd_en_reg    <= 1'b0;
            rd_addr_reg  <= '0;
            wordsize_reg <= WS_8;
        end else begin
            rd_en_reg    <= 1'b0;
            wordsize_reg <= WS_8;
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        addr_reg  <= i_ext_addr;
                        bound_reg <= i_memory_bound;
                        count_reg <= '0;
                        done_reg  <= 1'b0;
                        error_reg <= 1'b0;
                        code_reg  <= ERR_NONE;
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hdr_end > bound_ext) begin
                        error_reg <= 1'b1;
                        code_reg  <= ERR_HDR_BOUNDS;
                        state_reg <= ST_ERROR;
                    end else begin
                        state_reg <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!access_port.access_port_wait) begin
                        rd_en_reg    <= 1'b1;
                        rd_addr_reg  <= addr_reg;
                        wordsize_reg <= WS_32;
                        timer_reg    <= '0;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (access_port.access_port_rd_dv) begin
                        tag_reg    <= access_port.access_port_rd_data[31:16];
                        length_reg <= access_port.access_port_rd_data[15:0];
                        state_reg  <= ST_EVAL;
                    end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        error_reg <= 1'b1;
                        code_reg  <= ERR_TIMEOUT;
                        state_reg <= ST_ERROR;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (eval_code != ERR_NONE) begin
                        error_reg <= 1'b1;
                        code_reg  <= eval_code;
                        state_reg <= ST_ERROR;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                        if (next_addr == bound_ext) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            addr_reg  <= next_addr[BW-1:0];
                            state_reg <= ST_CHECK;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    nts_ext_table #(
        .MAX_EXTENSIONS(MAX_EXTENSIONS),
        .BW            (BW),
        .CW            (CW)
    ) u_table (
        .i_clk      (i_clk),
        .i_areset   (i_areset),
        .i_clear    (i_clear),
        .i_wr_en    (table_wr_en),
        .i_wr_index (count_reg),
        .i_wr_tag   (tag_reg),
        .i_wr_length(length_reg),
        .i_wr_addr  (addr_reg),
        .i_rd_index (i_ext_index),
        .i_count    (count_reg),
        .o_rd_tag   (o_ext_tag),
        .o_rd_length(o_ext_length),
        .o_rd_addr  (o_ext_addr)
    );

    assign o_busy       = !(state_reg == ST_IDLE || state_reg == ST_DONE || state_reg == ST_ERROR);
    assign o_done       = done_reg;
    assign o_error      = error_reg;
    assign o_error_code = code_reg;
    assign o_ext_count  = count_reg;

    assign access_port.access_port_addr     = rd_addr_reg;
    assign access_port.access_port_wordsize = wordsize_reg;
    assign access_port.access_port_rd_en    = rd_en_reg;
endmodule

// File: tb/tb_nts_extension_walker.sv
// Directed bench for the extension walker: RAM responder with a read-address
// scoreboard plus a per-walk result scoreboard.
module tb_nts_extension_walker;
    import nts_parser_pkg::*;

    localparam int BW = 13;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          i_areset, i_clear, i_start;
    logic [BW-1:0] ext_addr, mem_bound;
    logic          o_busy, o_done, o_error;
    logic [2:0]    o_error_code;
    logic [CW-1:0] o_ext_count, ext_index;
    logic [15:0]   o_ext_tag, o_ext_length;
    logic [BW-1:0] o_ext_addr;

    always #5 clk = ~clk;

    nts_extension_walker_if #(.BW(BW)) bus ();

    nts_extension_walker #(
        .ADDR_WIDTH    (10),
        .MAX_EXTENSIONS(8),
        .MIN_EXT_LENGTH(12),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .i_clk         (clk),
        .i_areset      (i_areset),
        .i_clear       (i_clear),
        .i_start       (i_start),
        .i_ext_addr    (ext_addr),
        .i_memory_bound(mem_bound),
        .access_port   (bus),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_error_code  (o_error_code),
        .o_ext_count   (o_ext_count),
        .i_ext_index   (ext_index),
        .o_ext_tag     (o_ext_tag),
        .o_ext_length  (o_ext_length),
        .o_ext_addr    (o_ext_addr)
    );

    typedef struct {
        logic       done;
        logic [2:0] code;
        logic [3:0] count;
    } result_t;

    int            errors = 0;
    int            checks = 0;
    int            lat = 2;
    bit            withhold = 1'b0;
    logic [31:0]   mem [int];
    logic [BW-1:0] exp_addr_q [$];
    result_t       res_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RAM model: answers each read after 'lat' cycles unless withheld.
    initial begin
        logic [BW-1:0] ea;
        logic [BW-1:0] a;
        bus.access_port_rd_dv   = 1'b0;
        bus.access_port_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.access_port_rd_en === 1'b1) begin
                a = bus.access_port_addr;
                $display("read addr=0x%0h wordsize=%0d", a, bus.access_port_wordsize);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_rd_en", {31'b0, bus.access_port_rd_en}, 32'd0);
                end else begin
                    ea = exp_addr_q.pop_front();
                    check("rd_addr", {19'b0, a}, {19'b0, ea});
                    check("rd_wordsize", {29'b0, bus.access_port_wordsize}, {29'b0, WS_32});
                end
                if (!withhold) begin
                    for (int k = 1; k < lat; k++) begin
                        @(posedge clk); #1;
                    end
                    bus.access_port_rd_dv   = 1'b1;
                    bus.access_port_rd_data = {32'h0, (mem.exists(int'(a)) ? mem[int'(a)] : 32'h0)};
                    @(posedge clk); #1;
                    bus.access_port_rd_dv   = 1'b0;
                    bus.access_port_rd_data = '0;
                end
            end
        end
    end

    task automatic put_hdr(input int a, input logic [15:0] tag, input logic [15:0] len);
        mem[a] = {tag, len};
    endtask

    task automatic expect_walk(input logic done, input logic [2:0] code, input logic [3:0] count);
        result_t r;
        r.done = done; r.code = code; r.count = count;
        res_q.push_back(r);
    endtask

    task automatic start_walk(input logic [BW-1:0] a, input logic [BW-1:0] b);
        @(posedge clk); #1;
        i_start = 1'b1; ext_addr = a; mem_bound = b;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic measure_rd_en(input string tag, input int release_at, input int exp_cycles);
        int cycles = 0;
        while (bus.access_port_rd_en !== 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == release_at) bus.access_port_wait = 1'b0;
        end
        check(tag, cycles, exp_cycles);
    endtask

    task automatic finish_walk(input string tag);
        int n = 0;
        result_t r;
        while (!(o_done || o_error) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_finished"}, {31'b0, (o_done | o_error)}, 32'd1);
        r = res_q.pop_front();
        check({tag, "_done"}, {31'b0, o_done}, {31'b0, r.done});
        check({tag, "_error"}, {31'b0, o_error}, {31'b0, ~r.done});
        check({tag, "_code"}, {29'b0, o_error_code}, {29'b0, r.code});
        check({tag, "_count"}, {28'b0, o_ext_count}, {28'b0, r.count});
        check({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
        check({tag, "_reads_left"}, exp_addr_q.size(), 32'd0);
        $display("walk %s: done=%0b error=%0b code=%0d count=%0d", tag, o_done, o_error, o_error_code, o_ext_count);
    endtask

    task automatic read_entry(input string tag, input int idx, input logic [15:0] t,
                              input logic [15:0] l, input logic [BW-1:0] a);
        ext_index = CW'(idx);
        @(posedge clk); #1;
        check({tag, "_tag"}, {16'b0, o_ext_tag}, {16'b0, t});
        check({tag, "_len"}, {16'b0, o_ext_length}, {16'b0, l});
        check({tag, "_addr"}, {19'b0, o_ext_addr}, {19'b0, a});
    endtask

    initial begin
        int n;
        i_areset = 1'b1; i_clear = 1'b0; i_start = 1'b0;
        ext_addr = '0; mem_bound = '0; ext_index = '0;
        bus.access_port_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_flags", {29'b0, o_done, o_error, bus.access_port_rd_en}, 32'd0);
        check("rst_count", {28'b0, o_ext_count}, 32'd0);
        check("rst_wordsize", {29'b0, bus.access_port_wordsize}, 32'd0);
        i_areset = 1'b0;
        read_entry("rst_entry0", 0, 16'h0, 16'h0, '0);

        // Two-extension chain ending exactly on the bound.
        mem.delete();
        put_hdr(32'h38, 16'h0104, 16'h0024);
        put_hdr(32'h5C, 16'h0404, 16'h000C);
        exp_addr_q.push_back(13'h38); exp_addr_q.push_back(13'h5C);
        expect_walk(1'b1, ERR_NONE, 4'd2);
        start_walk(13'h38, 13'h68);
        measure_rd_en("start_to_rd_en", 0, 2);
        finish_walk("chain2");
        read_entry("chain2_e0", 0, 16'h0104, 16'h0024, 13'h38);
        read_entry("chain2_e1", 1, 16'h0404, 16'h000C, 13'h5C);
        read_entry("chain2_e2", 2, 16'h0, 16'h0, '0);

        // Wait held high for 10 cycles delays rd_en by exactly 10 cycles.
        mem.delete();
        put_hdr(32'h38, 16'h0200, 16'h0030);
        exp_addr_q.push_back(13'h38);
        expect_walk(1'b1, ERR_NONE, 4'd1);
        bus.access_port_wait = 1'b1;
        start_walk(13'h38, 13'h68);
        measure_rd_en("wait_delay", 11, 12);
        finish_walk("wait10");

        mem.delete();
        put_hdr(32'h38, 16'h0104, 16'h0022);
        exp_addr_q.push_back(13'h38);
        expect_walk(1'b0, ERR_MISALIGNED, 4'd0);
        start_walk(13'h38, 13'h68);
        finish_walk("misaligned");

        mem.delete();
        put_hdr(32'h38, 16'h0104, 16'h0008);
        exp_addr_q.push_back(13'h38);
        expect_walk(1'b0, ERR_TOO_SHORT, 4'd0);
        start_walk(13'h38, 13'h68);
        finish_walk("too_short");

        expect_walk(1'b0, ERR_HDR_BOUNDS, 4'd0);
        start_walk(13'h66, 13'h68);
        finish_walk("hdr_oob");

        // Header ending exactly at the bound is still fetched.
        mem.delete();
        put_hdr(32'h64, 16'h0001, 16'h0004);
        exp_addr_q.push_back(13'h64);
        expect_walk(1'b0, ERR_TOO_SHORT, 4'd0);
        start_walk(13'h64, 13'h68);
        finish_walk("hdr_fits");

        // Nine 16-byte extensions against an eight-entry table.
        mem.delete();
        lat = 1;
        for (int i = 0; i < 9; i++) begin
            put_hdr(32'h100 + 16 * i, 16'h1000 + 16'(i), 16'h0010);
            exp_addr_q.push_back(BW'(13'h100 + 16 * i));
        end
        expect_walk(1'b0, ERR_TABLE_FULL, 4'd8);
        start_walk(13'h100, 13'h190);
        finish_walk("table_full");
        read_entry("full_e7", 7, 16'h1007, 16'h0010, 13'h170);

        mem.delete();
        lat = 3;
        put_hdr(32'h38, 16'h0104, 16'h0024);
        put_hdr(32'h5C, 16'h0404, 16'h0010);
        exp_addr_q.push_back(13'h38); exp_addr_q.push_back(13'h5C);
        expect_walk(1'b0, ERR_OVERRUN, 4'd1);
        start_walk(13'h38, 13'h68);
        finish_walk("overrun");
        read_entry("overrun_e0", 0, 16'h0104, 16'h0024, 13'h38);
        read_entry("overrun_e1", 1, 16'h0, 16'h0, '0);

        // No data ever returned: timeout after 64 cycles, not before.
        withhold = 1'b1;
        exp_addr_q.push_back(13'h38);
        expect_walk(1'b0, ERR_TIMEOUT, 4'd0);
        start_walk(13'h38, 13'h68);
        measure_rd_en("timeout_rd_en", 0, 2);
        repeat (60) @(posedge clk);
        #1;
        check("timeout_not_early", {31'b0, o_error}, 32'd0);
        finish_walk("timeout");
        withhold = 1'b0;

        // Clear during WAIT; the late read data must be ignored.
        mem.delete();
        lat = 5;
        put_hdr(32'h38, 16'h0104, 16'h0024);
        exp_addr_q.push_back(13'h38);
        start_walk(13'h38, 13'h68);
        n = 0;
        while (bus.access_port_rd_en !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("clear_saw_rd_en", {31'b0, bus.access_port_rd_en}, 32'd1);
        @(posedge clk); #1;
        i_clear = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0;
        check("clear_busy", {31'b0, o_busy}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("clear_busy_after_dv", {31'b0, o_busy}, 32'd0);
        check("clear_flags", {30'b0, o_done, o_error}, 32'd0);
        check("clear_count", {28'b0, o_ext_count}, 32'd0);
        check("clear_reads_left", exp_addr_q.size(), 32'd0);
        read_entry("clear_e0", 0, 16'h0, 16'h0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
